// File: rtl/move_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : move_io_sequencer
// Brief    : Hard-wired control sequencer for the T0..T3 fetch cycle and the
//            register-move / I/O subset (mfhi, mflo, in, out, nop, halt).
//            Drives the datapath control inputs as Moore outputs decoded from
//            the current state and the IR read back from the datapath.
// Options  : SINGLE_STEP_EN - adds input 'step' and a PAUSE state that every
//            non-halt retire parks in until step is asserted.
// Revision : 1.0 - initial release
// ============================================================================
module move_io_sequencer #(
    parameter logic [4:0] SEL_HI     = 5'b10000,
    parameter logic [4:0] SEL_LO     = 5'b10001,
    parameter logic [4:0] SEL_PC     = 5'b10100,
    parameter logic [4:0] SEL_MDR    = 5'b10101,
    parameter logic [4:0] SEL_INPORT = 5'b10110,
    parameter logic [4:0] SEL_RF     = 5'b00000,
    parameter int         CNT_W      = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      ir,
    output logic [4:0]       BusDataSelect,
    output logic             e_MAR,
    output logic             e_MDR,
    output logic             e_IR,
    output logic             e_HI,
    output logic             e_InPort,
    output logic             e_OutPort,
    output logic             incPC,
    output logic             ram_read,
    output logic             MDR_read,
    output logic             Gra,
    output logic             e_Rin,
    output logic             e_Rout,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_HALT  = 4'd7
`ifdef SINGLE_STEP_EN
        ,
        ST_PAUSE = 4'd8
`endif
    } state_t;

`ifdef SINGLE_STEP_EN
    localparam state_t ST_AFTER_RETIRE = ST_PAUSE;
`else
    localparam state_t ST_AFTER_RETIRE = ST_T0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             w_retire;
    logic [4:0]       w_op;

    // Register fields below the opcode are consumed by the datapath's
    // select/encode logic, not by the sequencer.
    logic             w_ir_unused;

    assign w_op        = ir[31:27];
    assign w_ir_unused = ^ir[26:0];
    assign instr_count = count_q;

    // State register and retired-instruction counter; clear wins over all.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore control decode from current state and opcode.
    always_comb begin
        state_d       = state_q;
        w_retire      = 1'b0;
        BusDataSelect = SEL_RF;
        e_MAR         = 1'b0;
        e_MDR         = 1'b0;
        e_IR          = 1'b0;
        e_HI          = 1'b0;
        e_InPort      = 1'b0;
        e_OutPort     = 1'b0;
        incPC         = 1'b0;
        ram_read      = 1'b0;
        MDR_read      = 1'b0;
        Gra           = 1'b0;
        e_Rin         = 1'b0;
        e_Rout        = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_T0;
            end
            ST_T0: begin
                BusDataSelect = SEL_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                state_d       = ST_T1;
            end
            ST_T1: begin
                ram_read = 1'b1;
                state_d  = ST_T2;
            end
            ST_T2: begin
                MDR_read = 1'b1;
                e_MDR    = 1'b1;
                state_d  = ST_T3;
            end
            ST_T3: begin
                BusDataSelect = SEL_MDR;
                e_IR          = 1'b1;
                state_d       = ST_T4;
            end
            ST_T4: begin
                case (w_op)
                    OP_MFHI, OP_MFLO: begin
                        BusDataSelect = (w_op == OP_MFHI) ? SEL_HI : SEL_LO;
                        Gra           = 1'b1;
                        e_Rin         = 1'b1;
                        w_retire      = 1'b1;
                        state_d       = ST_AFTER_RETIRE;
                    end
                    OP_IN: begin
                        // Latch the port first; the register write happens in T5.
                        e_InPort = 1'b1;
                        state_d  = ST_T5;
                    end
                    OP_OUT: begin
                        Gra       = 1'b1;
                        e_Rout    = 1'b1;
                        e_OutPort = 1'b1;
                        w_retire  = 1'b1;
                        state_d   = ST_AFTER_RETIRE;
                    end
                    OP_NOP: begin
                        w_retire = 1'b1;
                        state_d  = ST_AFTER_RETIRE;
                    end
                    OP_HALT: begin
                        w_retire = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: begin
                        // Unsupported opcode: flag it, skip counting, refetch.
                        illegal = 1'b1;
                        state_d = ST_T0;
                    end
                endcase
            end
            ST_T5: begin
                BusDataSelect = SEL_INPORT;
                Gra           = 1'b1;
                e_Rin         = 1'b1;
                w_retire      = 1'b1;
                state_d       = ST_AFTER_RETIRE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
`ifdef SINGLE_STEP_EN
            ST_PAUSE: begin
                if (step) state_d = ST_T0;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_move_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_io_sequencer
// Brief    : Self-checking bench for move_io_sequencer. Each instruction is
//            turned into the per-cycle list of control words it must produce,
//            and the retired count is tracked with modular arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_io_sequencer;

    localparam int CNT_W = 4;

    localparam logic [4:0] SEL_HI     = 5'b10000;
    localparam logic [4:0] SEL_LO     = 5'b10001;
    localparam logic [4:0] SEL_PC     = 5'b10100;
    localparam logic [4:0] SEL_MDR    = 5'b10101;
    localparam logic [4:0] SEL_INPORT = 5'b10110;
    localparam logic [4:0] SEL_RF     = 5'b00000;

    // Flag positions within the 14-bit control field of a control word.
    localparam logic [13:0] F_MAR     = 14'h2000;
    localparam logic [13:0] F_MDR     = 14'h1000;
    localparam logic [13:0] F_IR      = 14'h0800;
    localparam logic [13:0] F_HI      = 14'h0400;
    localparam logic [13:0] F_INPORT  = 14'h0200;
    localparam logic [13:0] F_OUTPORT = 14'h0100;
    localparam logic [13:0] F_INCPC   = 14'h0080;
    localparam logic [13:0] F_RAMRD   = 14'h0040;
    localparam logic [13:0] F_MDRRD   = 14'h0020;
    localparam logic [13:0] F_GRA     = 14'h0010;
    localparam logic [13:0] F_RIN     = 14'h0008;
    localparam logic [13:0] F_ROUT    = 14'h0004;
    localparam logic [13:0] F_HALTED  = 14'h0002;
    localparam logic [13:0] F_ILLEGAL = 14'h0001;
    localparam logic [13:0] F_NONE    = 14'h0000;

    logic             clock = 1'b0;
    logic             clear;
    logic             start;
    logic [31:0]      ir;
    logic [4:0]       BusDataSelect;
    logic             e_MAR, e_MDR, e_IR, e_HI, e_InPort, e_OutPort;
    logic             incPC, ram_read, MDR_read;
    logic             Gra, e_Rin, e_Rout, halted, illegal;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;
    int m_cnt    = 0;

    move_io_sequencer #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .ir           (ir),
        .BusDataSelect(BusDataSelect),
        .e_MAR        (e_MAR),
        .e_MDR        (e_MDR),
        .e_IR         (e_IR),
        .e_HI         (e_HI),
        .e_InPort     (e_InPort),
        .e_OutPort    (e_OutPort),
        .incPC        (incPC),
        .ram_read     (ram_read),
        .MDR_read     (MDR_read),
        .Gra          (Gra),
        .e_Rin        (e_Rin),
        .e_Rout       (e_Rout),
        .halted       (halted),
        .illegal      (illegal),
        .instr_count  (instr_count)
    );

    always #5 clock = ~clock;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [18:0] ctl_word();
        return {BusDataSelect, e_MAR, e_MDR, e_IR, e_HI, e_InPort, e_OutPort,
                incPC, ram_read, MDR_read, Gra, e_Rin, e_Rout, halted, illegal};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [4:0] sel, input logic [13:0] fl);
        check_val(tag, 32'(ctl_word()), 32'({sel, fl}));
    endtask

    task automatic check_cnt(input string tag);
        check_val(tag, 32'(instr_count), 32'(m_cnt));
    endtask

    // Precondition: the DUT is currently in the first fetch cycle.
    // Postcondition: one clock after the last execute cycle.
    task automatic run_instr(input logic [31:0] ir_v);
        logic [4:0]  op;
        logic [18:0] exp_q[$];
        bit          retires;
        op      = ir_v[31:27];
        ir      = ir_v;
        retires = 1'b1;
        exp_q   = {};
        exp_q.push_back({SEL_PC,  F_MAR | F_INCPC});
        exp_q.push_back({SEL_RF,  F_RAMRD});
        exp_q.push_back({SEL_RF,  F_MDRRD | F_MDR});
        exp_q.push_back({SEL_MDR, F_IR});
        case (op)
            5'b11001: exp_q.push_back({SEL_HI, F_GRA | F_RIN});
            5'b11000: exp_q.push_back({SEL_LO, F_GRA | F_RIN});
            5'b10110: begin
                exp_q.push_back({SEL_RF, F_INPORT});
                exp_q.push_back({SEL_INPORT, F_GRA | F_RIN});
            end
            5'b10111: exp_q.push_back({SEL_RF, F_GRA | F_ROUT | F_OUTPORT});
            5'b11010: exp_q.push_back({SEL_RF, F_NONE});
            5'b11011: exp_q.push_back({SEL_RF, F_NONE});
            default: begin
                exp_q.push_back({SEL_RF, F_ILLEGAL});
                retires = 1'b0;
            end
        endcase
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            check_val($sformatf("ctl op=%b cyc=%0d", op, i), 32'(ctl_word()), 32'(exp_q[i]));
        end
        check_cnt("cnt_before_retire");
        tick();
        if (retires) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        check_cnt($sformatf("cnt_after op=%b", op));
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] r;
        logic [4:0]  legal_ops [5];
        legal_ops[0] = 5'b11001;
        legal_ops[1] = 5'b11000;
        legal_ops[2] = 5'b10110;
        legal_ops[3] = 5'b10111;
        legal_ops[4] = 5'b11010;

        clear = 1'b1;
        start = 1'b0;
        ir    = 32'h0;
        tick();
        tick();
        check_ctl("reset_ctl", SEL_RF, F_NONE);
        check_cnt("reset_cnt");
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ctl("idle_hold", SEL_RF, F_NONE);
        end

        start = 1'b1;
        tick();
        start = 1'b0;

        // Directed: mfhi, in, illegal opcode, out, mflo, nop.
        run_instr(32'hC8800000);
        run_instr(32'hB1000000);
        run_instr(32'hF8000000);
        run_instr(32'hB8800000);
        run_instr(32'hC1000000);
        run_instr(32'hD0000000);

        // Randomized mix; start pulses mid-instruction must be ignored.
        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            if (r[0]) begin
                op = legal_ops[$urandom_range(0, 4)];
            end else begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'b11011) op = 5'b11010;
            end
            start = r[1];
            run_instr({op, r[31:5]});
            start = 1'b0;
        end

        // Counter wrap: bring it to all-ones, then one more retire.
        while (m_cnt != (1 << CNT_W) - 1) run_instr(32'hD0000000);
        run_instr(32'hD0000000);
        check_val("wrap_zero", 32'(instr_count), 32'h0);

        // clear during T2 aborts the instruction.
        tick();
        tick();
        check_ctl("t2_before_clear", SEL_RF, F_MDRRD | F_MDR);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_cnt = 0;
        check_ctl("clear_mid_ctl", SEL_RF, F_NONE);
        check_cnt("clear_mid_cnt");
        tick();
        check_ctl("clear_mid_idle", SEL_RF, F_NONE);

        // halt, then start pulses must not leave HALT.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_instr(32'hD8000000);
        check_ctl("halt_ctl", SEL_RF, F_HALTED);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check_ctl("halt_sticky", SEL_RF, F_HALTED);
        end
        check_cnt("halt_cnt");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_cnt = 0;
        check_ctl("halt_clear_ctl", SEL_RF, F_NONE);
        check_cnt("halt_clear_cnt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
